// File: rtl/mips_lite_pkg.sv
// Shared types for the mips-lite register-file writeback path: data/address widths,
// the hardwired-zero register index and the queued writeback request.
package mips_lite_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular storage for pending register writebacks: pointers, occupancy count,
// full/empty flags, and a view of every slot so the parent can search by age.
module wb_fifo
  import mips_lite_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_flush,
  input  wb_req_t                   i_req,
  output wb_req_t                   o_head,
  output wb_req_t [DEPTH-1:0]       o_mem,
  output logic [$clog2(DEPTH)-1:0]  o_rd_ptr,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_push;

  assign w_push = i_push & ~i_flush;

  // Entry storage is deliberately left unreset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_req;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head   = r_mem[r_rd_ptr];
  assign o_mem    = r_mem;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/reg_wb_queue.sv
// Writeback queue in front of the register-file write port with newest-value operand
// bypass. Define WB_BYPASS_EN for bypass; otherwise a hazard interlock stalls wb_ready.
module reg_wb_queue
  import mips_lite_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush,
  input  logic                     rf_hold,
  output logic                     reg_write,
  output logic [ADDR_W-1:0]        rd_in,
  output logic [DATA_W-1:0]        from_reg_src,
  input  logic [ADDR_W-1:0]        rs_in,
  input  logic [ADDR_W-1:0]        rt_in,
  output logic                     rs_hit,
  output logic                     rt_hit,
  output logic [DATA_W-1:0]        rs_fwd,
  output logic [DATA_W-1:0]        rt_fwd,
  output logic [$clog2(DEPTH):0]   pend_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t              w_req;
  wb_req_t              w_head;
  wb_req_t [DEPTH-1:0]  w_mem;
  logic [PTR_W-1:0]     w_rd_ptr;
  logic [CNT_W-1:0]     w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_hazard;

  assign w_req = '{rd: wb_rd, data: wb_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .i_rst_n  (rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (flush),
    .i_req    (w_req),
    .o_head   (w_head),
    .o_mem    (w_mem),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign w_pop    = ~w_empty & ~rf_hold & ~flush;
  assign wb_ready = (~w_full | w_pop) & ~w_hazard;
  // Writes to $0 complete the handshake but are never queued.
  assign w_push   = wb_valid & wb_ready & (wb_rd != REG_ZERO) & ~flush;

  assign reg_write    = w_pop;
  assign rd_in        = w_empty ? '0 : w_head.rd;
  assign from_reg_src = w_empty ? '0 : w_head.data;
  assign pend_cnt     = w_count;

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to newest so the youngest matching entry overwrites earlier ones.
  always_comb begin
    w_idx    = '0;
    rs_hit   = 1'b0;
    rt_hit   = 1'b0;
    rs_fwd   = '0;
    rt_fwd   = '0;
    w_hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < w_count) begin
        if (rs_in != REG_ZERO && w_mem[w_idx].rd == rs_in) begin
          rs_hit = 1'b1;
          rs_fwd = w_mem[w_idx].data;
        end
        if (rt_in != REG_ZERO && w_mem[w_idx].rd == rt_in) begin
          rt_hit = 1'b1;
          rt_fwd = w_mem[w_idx].data;
        end
      end
    end
  end
`else
  logic [PTR_W-1:0] w_idx;

  assign rs_hit = 1'b0;
  assign rt_hit = 1'b0;
  assign rs_fwd = '0;
  assign rt_fwd = '0;

  always_comb begin
    w_idx    = '0;
    w_hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < w_count &&
          ((rs_in != REG_ZERO && w_mem[w_idx].rd == rs_in) ||
           (rt_in != REG_ZERO && w_mem[w_idx].rd == rt_in)))
        w_hazard = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_reg_wb_queue;
  import mips_lite_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              rf_hold;
  logic              reg_write;
  logic [ADDR_W-1:0] rd_in;
  logic [DATA_W-1:0] from_reg_src;
  logic [ADDR_W-1:0] rs_in;
  logic [ADDR_W-1:0] rt_in;
  logic              rs_hit;
  logic              rt_hit;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [2:0]        pend_cnt;

  typedef struct {
    int rd;
    int data;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  reg_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .rf_hold      (rf_hold),
    .reg_write    (reg_write),
    .rd_in        (rd_in),
    .from_reg_src (from_reg_src),
    .rs_in        (rs_in),
    .rt_in        (rt_in),
    .rs_hit       (rs_hit),
    .rt_hit       (rt_hit),
    .rs_fwd       (rs_fwd),
    .rt_fwd       (rt_fwd),
    .pend_cnt     (pend_cnt)
  );

  // Reference model: a plain list of pending writes, oldest first.
  function automatic bit m_pop();
    return (mq.size() != 0) && !rf_hold && !flush;
  endfunction

  function automatic bit m_haz();
`ifdef WB_BYPASS_EN
    return 1'b0;
`else
    foreach (mq[i])
      if ((rs_in != 0 && mq[i].rd == int'(rs_in)) || (rt_in != 0 && mq[i].rd == int'(rt_in)))
        return 1'b1;
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return ((mq.size() < DEPTH) || m_pop()) && !m_haz();
  endfunction

  function automatic bit m_hit(int a);
`ifdef WB_BYPASS_EN
    if (a == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int m_fwd(int a);
`ifdef WB_BYPASS_EN
    if (a == 0) return 0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].rd == a) return mq[i].data;
`endif
    return 0;
  endfunction

  task automatic drive(bit v, int rd, int d, bit fl, bit h, int rs, int rt);
    wb_valid = v;
    wb_rd    = ADDR_W'(rd);
    wb_data  = DATA_W'(d);
    flush    = fl;
    rf_hold  = h;
    rs_in    = ADDR_W'(rs);
    rt_in    = ADDR_W'(rt);
  endtask

  task automatic tick();
    bit   p;
    bit   acc;
    bit   fl;
    ent_t e;
    p      = m_pop();
    acc    = wb_valid && m_ready() && (wb_rd != 0);
    fl     = flush;
    e.rd   = int'(wb_rd);
    e.data = int'(wb_data);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (p) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (reg_write !== 1'b0) $display("FAIL rst_wr: got %0d want 0", reg_write); else n_pass++;
    n_checks++; if (rd_in !== '0) $display("FAIL rst_rd: got %0d want 0", rd_in); else n_pass++;
    n_checks++; if (from_reg_src !== '0) $display("FAIL rst_data: got %0d want 0", from_reg_src); else n_pass++;
    n_checks++; if (wb_ready !== 1'b1) $display("FAIL rst_ready: got %0d want 1", wb_ready); else n_pass++;
    n_checks++; if (pend_cnt !== 3'd0) $display("FAIL rst_cnt: got %0d want 0", pend_cnt); else n_pass++;
    n_checks++; if (rs_hit !== 1'b0 || rt_hit !== 1'b0) $display("FAIL rst_hit: got %0d/%0d want 0/0", rs_hit, rt_hit); else n_pass++;
    rst = 1'b1;
    mq.delete();
  endtask

  task automatic test_single();
    drive(1, 1, 5, 0, 0, 0, 0);
    #1;
    n_checks++; if (wb_ready !== 1'b1) $display("FAIL t1_ready: got %0d want 1", wb_ready); else n_pass++;
    n_checks++; if (reg_write !== 1'b0) $display("FAIL t1_wr_empty: got %0d want 0", reg_write); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (reg_write !== 1'b1) $display("FAIL t1_wr: got %0d want 1", reg_write); else n_pass++;
    n_checks++; if (rd_in !== 3'd1) $display("FAIL t1_rd: got %0d want 1", rd_in); else n_pass++;
    n_checks++; if (from_reg_src !== 8'd5) $display("FAIL t1_data: got %0d want 5", from_reg_src); else n_pass++;
    n_checks++; if (pend_cnt !== 3'd1) $display("FAIL t1_cnt1: got %0d want 1", pend_cnt); else n_pass++;
    tick();
    n_checks++; if (pend_cnt !== 3'd0) $display("FAIL t1_cnt0: got %0d want 0", pend_cnt); else n_pass++;
    n_checks++; if (reg_write !== 1'b0 || rd_in !== '0) $display("FAIL t1_idle: got wr=%0d rd=%0d want 0/0", reg_write, rd_in); else n_pass++;
  endtask

  task automatic test_hold_bypass();
    drive(1, 1, 5, 0, 1, 0, 0);  tick();
    drive(1, 2, 4, 0, 1, 0, 0);  tick();
    drive(1, 1, 20, 0, 1, 0, 0); tick();
    drive(1, 3, 7, 0, 1, 0, 0);  tick();
    drive(0, 0, 0, 0, 1, 1, 2);
    #1;
    n_checks++; if (pend_cnt !== 3'd4) $display("FAIL t2_cnt: got %0d want 4", pend_cnt); else n_pass++;
    n_checks++; if (wb_ready !== 1'b0) $display("FAIL t2_ready: got %0d want 0", wb_ready); else n_pass++;
    n_checks++; if (reg_write !== 1'b0) $display("FAIL t2_hold_wr: got %0d want 0", reg_write); else n_pass++;
`ifdef WB_BYPASS_EN
    n_checks++; if (rs_hit !== 1'b1 || rs_fwd !== 8'd20) $display("FAIL t2_rs: got hit=%0d fwd=%0d want 1/20", rs_hit, rs_fwd); else n_pass++;
    n_checks++; if (rt_hit !== 1'b1 || rt_fwd !== 8'd4) $display("FAIL t2_rt: got hit=%0d fwd=%0d want 1/4", rt_hit, rt_fwd); else n_pass++;
`else
    n_checks++; if (rs_hit !== 1'b0 || rs_fwd !== 8'd0) $display("FAIL t2_rs_tied: got hit=%0d fwd=%0d want 0/0", rs_hit, rs_fwd); else n_pass++;
    n_checks++; if (rt_hit !== 1'b0 || rt_fwd !== 8'd0) $display("FAIL t2_rt_tied: got hit=%0d fwd=%0d want 0/0", rt_hit, rt_fwd); else n_pass++;
`endif
    rs_in = 3'd5;
    #1;
    n_checks++; if (rs_hit !== 1'b0 || rs_fwd !== 8'd0) $display("FAIL t2_rs_miss: got hit=%0d fwd=%0d want 0/0", rs_hit, rs_fwd); else n_pass++;
  endtask

  task automatic test_drain_order();
    int exp_rd[4]   = '{1, 2, 1, 3};
    int exp_data[4] = '{5, 4, 20, 7};
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (reg_write !== 1'b1 || rd_in !== ADDR_W'(exp_rd[i]) || from_reg_src !== DATA_W'(exp_data[i]))
        $display("FAIL t3_order%0d: got wr=%0d rd=%0d data=%0d want 1/%0d/%0d",
                 i, reg_write, rd_in, from_reg_src, exp_rd[i], exp_data[i]);
      else n_pass++;
      tick();
    end
    n_checks++; if (pend_cnt !== 3'd0 || reg_write !== 1'b0) $display("FAIL t3_empty: got cnt=%0d wr=%0d want 0/0", pend_cnt, reg_write); else n_pass++;
  endtask

  task automatic test_full_pushpop();
    drive(1, 5, 11, 0, 1, 0, 0); tick();
    drive(1, 6, 12, 0, 1, 0, 0); tick();
    drive(1, 7, 13, 0, 1, 0, 0); tick();
    drive(1, 1, 14, 0, 1, 0, 0); tick();
    drive(1, 4, 9, 0, 0, 0, 0);
    #1;
    n_checks++; if (wb_ready !== 1'b1 || reg_write !== 1'b1) $display("FAIL t4_ready: got ready=%0d wr=%0d want 1/1", wb_ready, reg_write); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (pend_cnt !== 3'd4 || rd_in !== 3'd6) $display("FAIL t4_cnt: got cnt=%0d rd=%0d want 4/6", pend_cnt, rd_in); else n_pass++;
    repeat (3) tick();
    n_checks++; if (reg_write !== 1'b1 || rd_in !== 3'd4 || from_reg_src !== 8'd9) $display("FAIL t4_tail: got wr=%0d rd=%0d data=%0d want 1/4/9", reg_write, rd_in, from_reg_src); else n_pass++;
    tick();
    n_checks++; if (pend_cnt !== 3'd0) $display("FAIL t4_drained: got %0d want 0", pend_cnt); else n_pass++;
  endtask

  task automatic test_interlock();
    drive(1, 3, 33, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 3, 0);
    #1;
`ifdef WB_BYPASS_EN
    n_checks++; if (wb_ready !== 1'b1 || rs_hit !== 1'b1 || rs_fwd !== 8'd33) $display("FAIL t7_byp: got ready=%0d hit=%0d fwd=%0d want 1/1/33", wb_ready, rs_hit, rs_fwd); else n_pass++;
`else
    n_checks++; if (wb_ready !== 1'b0) $display("FAIL t7_stall_rs: got %0d want 0", wb_ready); else n_pass++;
    drive(0, 0, 0, 0, 1, 0, 3);
    #1;
    n_checks++; if (wb_ready !== 1'b0) $display("FAIL t7_stall_rt: got %0d want 0", wb_ready); else n_pass++;
`endif
    drive(0, 0, 0, 0, 1, 2, 0);
    #1;
    n_checks++; if (wb_ready !== 1'b1 || rs_hit !== 1'b0) $display("FAIL t7_nomatch: got ready=%0d hit=%0d want 1/0", wb_ready, rs_hit); else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reg_zero();
    drive(1, 0, 99, 0, 0, 0, 0);
    #1;
    n_checks++; if (wb_ready !== 1'b1) $display("FAIL t5_ready: got %0d want 1", wb_ready); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (pend_cnt !== 3'd0 || reg_write !== 1'b0) $display("FAIL t5_nopush: got cnt=%0d wr=%0d want 0/0", pend_cnt, reg_write); else n_pass++;
    n_checks++; if (rs_hit !== 1'b0) $display("FAIL t5_rs0: got %0d want 0", rs_hit); else n_pass++;
  endtask

  task automatic test_flush_reset();
    drive(1, 1, 1, 0, 1, 0, 0); tick();
    drive(1, 2, 2, 0, 1, 0, 0); tick();
    drive(1, 3, 3, 0, 1, 0, 0); tick();
    drive(1, 6, 66, 1, 0, 0, 0);
    #1;
    n_checks++; if (reg_write !== 1'b0) $display("FAIL t6_flush_wr: got %0d want 0", reg_write); else n_pass++;
    n_checks++; if (wb_ready !== 1'b1 || pend_cnt !== 3'd3) $display("FAIL t6_pre: got ready=%0d cnt=%0d want 1/3", wb_ready, pend_cnt); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (pend_cnt !== 3'd0 || reg_write !== 1'b0) $display("FAIL t6_flushed: got cnt=%0d wr=%0d want 0/0", pend_cnt, reg_write); else n_pass++;
    drive(1, 4, 40, 0, 1, 0, 0); tick();
    drive(1, 5, 50, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (reg_write !== 1'b1 || rd_in !== 3'd4) $display("FAIL t6_drain: got wr=%0d rd=%0d want 1/4", reg_write, rd_in); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (reg_write !== 1'b0 || pend_cnt !== 3'd0 || rd_in !== '0) $display("FAIL t6_async_rst: got wr=%0d cnt=%0d rd=%0d want 0/0/0", reg_write, pend_cnt, rd_in); else n_pass++;
    mq.delete();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int rs;
    int rt;
    for (int c = 0; c < 400; c++) begin
      rs = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : 0;
      rt = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : 0;
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, rs, rt);
      #1;
      n_checks++;
      if (reg_write !== m_pop() || wb_ready !== m_ready() || pend_cnt !== 3'(mq.size()))
        $display("FAIL rnd_ctl%0d: got wr=%0d ready=%0d cnt=%0d want %0d/%0d/%0d",
                 c, reg_write, wb_ready, pend_cnt, m_pop(), m_ready(), mq.size());
      else n_pass++;
      n_checks++;
      if (rd_in !== ADDR_W'(mq.size() != 0 ? mq[0].rd : 0) ||
          from_reg_src !== DATA_W'(mq.size() != 0 ? mq[0].data : 0))
        $display("FAIL rnd_head%0d: got rd=%0d data=%0d want %0d/%0d", c, rd_in, from_reg_src,
                 mq.size() != 0 ? mq[0].rd : 0, mq.size() != 0 ? mq[0].data : 0);
      else n_pass++;
      n_checks++;
      if (rs_hit !== m_hit(rs) || rs_fwd !== DATA_W'(m_fwd(rs)) ||
          rt_hit !== m_hit(rt) || rt_fwd !== DATA_W'(m_fwd(rt)))
        $display("FAIL rnd_byp%0d: got rs=%0d/%0d rt=%0d/%0d want %0d/%0d %0d/%0d", c,
                 rs_hit, rs_fwd, rt_hit, rt_fwd, m_hit(rs), m_fwd(rs), m_hit(rt), m_fwd(rt));
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    tick();
    test_single();
    test_hold_bypass();
    test_drain_order();
    test_full_pushpop();
    test_interlock();
    test_reg_zero();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
